uart_rx_param: RTL and testbench
================================

# uart_rx_param

Parametrised next-generation UART receive core: oversampled start detection with majority-vote bit sampling, runtime-selectable 5–8 data bits, five parity modes, 1 or 2 stop bits, LSB- or MSB-first order, break detection, and a first-word-fall-through receive FIFO that carries per-word error status. It sits between the baud/acquisition tick generator and the host register interface, in place of the fixed-format receive core.

## Interface
- OVERSAMPLE, 16, AcqSig_i ticks per bit; even, 8..32
- FIFO_DEPTH, 64, receive FIFO words; power of two, 4..256
- clk  in  1  system clock; all logic on rising edge
- rst  in  1  synchronous, active-high reset
- AcqSig_i  in  1  one-cycle oversample tick, OVERSAMPLE per bit time
- Rx_i  in  1  asynchronous serial line, idle high
- DataBits_i  in  2  0→5, 1→6, 2→7, 3→8 data bits
- ParityMode_i  in  3  0 none, 1 odd, 2 even, 3 mark (1), 4 space (0); 5–7 treated as none
- TwoStop_i  in  1  1 = two stop bits checked
- p_MsbFirst_i  in  1  1 = first data bit received is the MSB of the word
- n_rd_i  in  1  active-low FIFO pop, one word per low cycle
- data_o  out  11  {break, frame_err, parity_err, data[7:0]}; unused high data bits zero
- p_empty_o  out  1  FIFO empty
- p_full_o  out  1  FIFO full
- Level_o  out  $clog2(FIFO_DEPTH)+1  words held
- p_Busy_o  out  1  FSM not IDLE
- ParityErrorNum_o / FrameErrorNum_o / OverrunNum_o  out  8 each  saturating event counters

## Operation
- Rx_i passes through a 2-flop synchroniser (reset value 1); all decisions use the synchronised line.
- Config inputs are latched at the start edge; changes mid-frame have no effect on that frame.
- Tick counter runs 0..OVERSAMPLE-1 per bit. Samples are taken at counts M-1, M, M+1 (M = OVERSAMPLE/2); the bit value is the 2-of-3 majority, resolved on the M+1 tick.
- FSM states: IDLE, START, DATA, PARITY, STOP1, STOP2, BRK_WAIT.
- IDLE: a synchronised high→low transition seen on any cycle → START, tick counter cleared.
- START: majority 1 → false start, back to IDLE with no write; majority 0 → DATA.
- DATA: one bit per bit time, shifted according to p_MsbFirst_i; after N bits → PARITY if mode ≠ none, else STOP1.
- PARITY: parity_err = received bit ≠ expected (odd: XOR of data ^ 1; even: XOR of data; mark 1; space 0).
- STOP1: frame_err = sampled 0. If TwoStop_i → STOP2, which ORs its own check into frame_err. The word is written on the resolving tick of the last stop bit, so the FSM is back in IDLE at mid-stop for resynchronisation.
- Break: data all zero, parity bit (if any) zero, and the last stop bit zero → break=1 and frame_err=1, one word written, then BRK_WAIT until the line reads 1 on a resolving tick → IDLE. A break longer than one frame produces exactly one word.
- Counters increment once per written or dropped word that carries the corresponding error (a break counts as a frame error) and saturate at 255.
- FIFO:
  - Write while full: the word is dropped, OverrunNum_o increments, and the FIFO contents are unchanged.
  - Pop while empty is ignored.
  - Simultaneous pop and write when full: both take effect and Level_o is unchanged.
  - Pointers wrap modulo FIFO_DEPTH.
- Reset mid-frame: the FSM returns to IDLE, the FIFO is flushed, and the partial frame is discarded.

## Timing
- Reset values: data_o 0, p_empty_o 1, p_full_o 0, Level_o 0, p_Busy_o 0, all counters 0.
- Start detection occurs 2 cycles after the Rx_i edge because of the synchroniser.
- FIFO write occurs in the cycle after the resolving AcqSig_i tick of the last stop bit.
- data_o, p_empty_o and Level_o update on the following clock edge.
- data_o is first-word-fall-through: the head word is valid whenever p_empty_o=0. n_rd_i low at edge k causes data_o to show the next word, and Level_o to decrement, after edge k.
- p_full_o, p_empty_o and Level_o are registered and mutually consistent every cycle.

## Test plan
- Frame 8N1, LSB first, byte 0xA5, OVERSAMPLE=16 → one word, data_o=11'h0A5, no errors, Level_o 0→1.
- Frame 8E1 with byte 0x3C and parity bit forced to 1 → data_o=11'h13C, ParityErrorNum_o=1; then 7O2 MSB-first 0x55 correct → data_o=11'h055.
- Rx low for 5 ticks then high → no word, p_Busy_o returns to 0 at the START resolving tick; a following 0x81 frame is received correctly.
- Rx low for 30 bit times, then high → exactly one word 11'h600, FrameErrorNum_o=1. The next frame 0xFF received correctly.
- FIFO_DEPTH=4: send 5 frames 0x01..0x05 with no reads → p_full_o=1, OverrunNum_o=1; pops return 0x01..0x04 in order, then p_empty_o=1.
- Pop in the same cycle as a write while full → Level_o stays 4, no overrun; assert rst mid-frame → all outputs at reset values on the next cycle.

Source files
------------

// File: rtl/uart_rx_param_if.sv
// Host-side receive FIFO port of uart_rx_param: first-word-fall-through head
// word plus occupancy flags.
interface uart_rx_param_if #(
  parameter int FIFO_DEPTH = 64
);
  localparam int LW = $clog2(FIFO_DEPTH) + 1;

  // Handshake: p_empty_o = 0 means data_o holds a valid head word. n_rd_i = 0
  // means the host takes it. A word transfers on each rising clk edge where
  // both hold. Asserting n_rd_i low while empty has no effect.
  logic          n_rd_i;
  logic [10:0]   data_o;
  logic          p_empty_o;
  logic          p_full_o;
  logic [LW-1:0] Level_o;

  modport master (
    output n_rd_i,
    input  data_o, p_empty_o, p_full_o, Level_o
  );

  modport slave (
    input  n_rd_i,
    output data_o, p_empty_o, p_full_o, Level_o
  );
endinterface

// File: rtl/uart_rx_param.sv
// Oversampled UART receiver with runtime frame format, break detection and a
// FWFT receive FIFO carrying {break, frame_err, parity_err, data} per word.
module uart_rx_param #(
  parameter int OVERSAMPLE = 16,
  parameter int FIFO_DEPTH = 64
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 AcqSig_i,
  input  logic                 Rx_i,
  input  logic [1:0]           DataBits_i,
  input  logic [2:0]           ParityMode_i,
  input  logic                 TwoStop_i,
  input  logic                 p_MsbFirst_i,
  uart_rx_param_if.slave       fifo,
  output logic                 p_Busy_o,
  output logic [7:0]           ParityErrorNum_o,
  output logic [7:0]           FrameErrorNum_o,
  output logic [7:0]           OverrunNum_o,
  output logic [2:0]           dbg_state
);

  localparam int CW = $clog2(OVERSAMPLE);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [CW-1:0] CNT_LAST = CW'(OVERSAMPLE - 1);
  localparam logic [CW-1:0] CNT_S0   = CW'(OVERSAMPLE / 2 - 1);
  localparam logic [CW-1:0] CNT_S1   = CW'(OVERSAMPLE / 2);
  localparam logic [CW-1:0] CNT_RES  = CW'(OVERSAMPLE / 2 + 1);

  typedef enum logic [2:0] {
    IDLE, START, DATA, PARITY, STOP1, STOP2, BRK_WAIT
  } state_t;

  state_t state_q, state_d;

  logic          rx_s1, rx_s2, rx_q, fall;
  logic [CW-1:0] cnt;
  logic          smp0, smp1, maj, res_tick;
  logic [1:0]    bits_q;
  logic [2:0]    par_mode_q;
  logic          two_stop_q, msb_q;
  logic [7:0]    shreg, data_al;
  logic [2:0]    bit_idx, last_idx;
  logic          par_err_q, frm_q, par_zero_q, exp_par, is_break;
  logic          wr_now, wr_q;
  logic [10:0]   word_now, word_q;

  // Line synchroniser; rx_q is one more stage used only for edge detection.
  always_ff @(posedge clk) begin
    if (rst) begin
      rx_s1 <= 1'b1;
      rx_s2 <= 1'b1;
      rx_q  <= 1'b1;
    end else begin
      rx_s1 <= Rx_i;
      rx_s2 <= rx_s1;
      rx_q  <= rx_s2;
    end
  end

  assign fall     = rx_q & ~rx_s2;
  assign res_tick = AcqSig_i && (cnt == CNT_RES);
  assign maj      = (smp0 & smp1) | (smp0 & rx_s2) | (smp1 & rx_s2);
  assign last_idx = {1'b0, bits_q} + 3'd4;
  // LSB-first words enter from the top; shift down so unused bits read zero.
  assign data_al  = msb_q ? shreg : (shreg >> (2'd3 - bits_q));
  assign is_break = (data_al == 8'd0) && par_zero_q && !maj;
  assign word_now = {is_break, frm_q | ~maj, par_err_q, data_al};

  always_comb begin
    exp_par = 1'b0;
    case (par_mode_q)
      3'd1:    exp_par = ~(^data_al);
      3'd2:    exp_par = ^data_al;
      3'd3:    exp_par = 1'b1;
      default: exp_par = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    wr_now  = 1'b0;
    case (state_q)
      IDLE:     if (fall) state_d = START;
      START:    if (res_tick) state_d = maj ? IDLE : DATA;
      DATA:     if (res_tick && bit_idx == last_idx)
                  state_d = (par_mode_q != 3'd0) ? PARITY : STOP1;
      PARITY:   if (res_tick) state_d = STOP1;
      STOP1:    if (res_tick) begin
                  if (two_stop_q) begin
                    state_d = STOP2;
                  end else begin
                    wr_now  = 1'b1;
                    state_d = is_break ? BRK_WAIT : IDLE;
                  end
                end
      STOP2:    if (res_tick) begin
                  wr_now  = 1'b1;
                  state_d = is_break ? BRK_WAIT : IDLE;
                end
      BRK_WAIT: if (res_tick && maj) state_d = IDLE;
      default:  state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt        <= '0;
      smp0       <= 1'b1;
      smp1       <= 1'b1;
      bits_q     <= 2'd3;
      par_mode_q <= 3'd0;
      two_stop_q <= 1'b0;
      msb_q      <= 1'b0;
      shreg      <= 8'd0;
      bit_idx    <= 3'd0;
      par_err_q  <= 1'b0;
      frm_q      <= 1'b0;
      par_zero_q <= 1'b1;
      wr_q       <= 1'b0;
      word_q     <= 11'd0;
    end else begin
      wr_q   <= wr_now;
      word_q <= word_now;
      if (state_q == IDLE && fall) begin
        cnt        <= '0;
        bits_q     <= DataBits_i;
        par_mode_q <= (ParityMode_i > 3'd4) ? 3'd0 : ParityMode_i;
        two_stop_q <= TwoStop_i;
        msb_q      <= p_MsbFirst_i;
        shreg      <= 8'd0;
        bit_idx    <= 3'd0;
        par_err_q  <= 1'b0;
        frm_q      <= 1'b0;
        par_zero_q <= 1'b1;
      end else if (AcqSig_i) begin
        cnt <= (cnt == CNT_LAST) ? '0 : cnt + CW'(1);
      end
      if (AcqSig_i && cnt == CNT_S0) smp0 <= rx_s2;
      if (AcqSig_i && cnt == CNT_S1) smp1 <= rx_s2;
      if (res_tick) begin
        case (state_q)
          DATA: begin
            shreg   <= msb_q ? {shreg[6:0], maj} : {maj, shreg[7:1]};
            bit_idx <= bit_idx + 3'd1;
          end
          PARITY: begin
            par_err_q  <= (maj != exp_par);
            par_zero_q <= ~maj;
          end
          STOP1:   frm_q <= ~maj;
          default: ;
        endcase
      end
    end
  end

  // Receive FIFO. data_o is registered and always reflects the next head word.
  logic [10:0]   mem [FIFO_DEPTH];
  logic [AW-1:0] rptr, wptr, next_idx;
  logic [AW:0]   count, count_n, rem;
  logic          pop, push, overrun;
  logic [10:0]   head_n;

  assign pop      = ~fifo.n_rd_i && ~fifo.p_empty_o;
  assign push     = wr_q && (~fifo.p_full_o || pop);
  assign overrun  = wr_q && fifo.p_full_o && ~pop;
  assign rem      = count - {{AW{1'b0}}, pop};
  assign next_idx = pop ? rptr + AW'(1) : rptr;

  always_comb begin
    count_n = count;
    case ({push, pop})
      2'b10:   count_n = count + (AW+1)'(1);
      2'b01:   count_n = count - (AW+1)'(1);
      default: count_n = count;
    endcase
    head_n = 11'd0;
    if (count_n != '0) head_n = (rem == '0) ? word_q : mem[next_idx];
  end

  always_ff @(posedge clk) begin
    if (push) mem[wptr] <= word_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rptr           <= '0;
      wptr           <= '0;
      count          <= '0;
      fifo.data_o    <= 11'd0;
      fifo.p_empty_o <= 1'b1;
      fifo.p_full_o  <= 1'b0;
    end else begin
      if (push) wptr <= wptr + AW'(1);
      if (pop)  rptr <= rptr + AW'(1);
      count          <= count_n;
      fifo.data_o    <= head_n;
      fifo.p_empty_o <= (count_n == '0);
      fifo.p_full_o  <= (count_n == (AW+1)'(FIFO_DEPTH));
    end
  end

  assign fifo.Level_o = count;

  // Error counters see every completed word, including ones lost to overrun.
  always_ff @(posedge clk) begin
    if (rst) begin
      ParityErrorNum_o <= 8'd0;
      FrameErrorNum_o  <= 8'd0;
      OverrunNum_o     <= 8'd0;
    end else if (wr_q) begin
      if (word_q[8] && ParityErrorNum_o != 8'hFF) ParityErrorNum_o <= ParityErrorNum_o + 8'd1;
      if (word_q[9] && FrameErrorNum_o  != 8'hFF) FrameErrorNum_o  <= FrameErrorNum_o + 8'd1;
      if (overrun   && OverrunNum_o     != 8'hFF) OverrunNum_o     <= OverrunNum_o + 8'd1;
    end
  end

  assign p_Busy_o  = (state_q != IDLE);
  assign dbg_state = state_q;

endmodule

// File: tb/tb_uart_rx_param.sv
// Directed bench for uart_rx_param: frame formats, false start, break,
// FIFO overrun / simultaneous pop+write, and mid-frame reset.
module tb_uart_rx_param;
  localparam int OS         = 16;
  localparam int DEPTH      = 4;
  localparam int TICK_DIV   = 4;
  localparam int BIT_CLKS   = OS * TICK_DIV;

  logic       clk = 1'b0;
  logic       rst;
  logic       AcqSig_i;
  logic       Rx_i;
  logic [1:0] DataBits_i;
  logic [2:0] ParityMode_i;
  logic       TwoStop_i;
  logic       p_MsbFirst_i;
  logic       p_Busy_o;
  logic [7:0] ParityErrorNum_o, FrameErrorNum_o, OverrunNum_o;
  logic [2:0] dbg_state;

  int n_cmp = 0;
  int n_err = 0;

  uart_rx_param_if #(.FIFO_DEPTH(DEPTH)) fifo_bus ();

  uart_rx_param #(.OVERSAMPLE(OS), .FIFO_DEPTH(DEPTH)) dut (
    .clk              (clk),
    .rst              (rst),
    .AcqSig_i         (AcqSig_i),
    .Rx_i             (Rx_i),
    .DataBits_i       (DataBits_i),
    .ParityMode_i     (ParityMode_i),
    .TwoStop_i        (TwoStop_i),
    .p_MsbFirst_i     (p_MsbFirst_i),
    .fifo             (fifo_bus),
    .p_Busy_o         (p_Busy_o),
    .ParityErrorNum_o (ParityErrorNum_o),
    .FrameErrorNum_o  (FrameErrorNum_o),
    .OverrunNum_o     (OverrunNum_o),
    .dbg_state        (dbg_state)
  );

  // Clock and oversample tick
  always #5 clk = ~clk;

  initial begin
    int div;
    div = 0;
    AcqSig_i = 1'b0;
    forever begin
      @(negedge clk);
      div = (div + 1) % TICK_DIV;
      AcqSig_i = (div == 0);
    end
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic wait_clks(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic drive_bit(input logic b);
    Rx_i = b;
    wait_clks(BIT_CLKS);
  endtask

  // pmode: 0 none, 1 odd, 2 even, 3 mark, 4 space
  task automatic send_frame(input logic [7:0] d, input int nbits, input int pmode,
                            input bit two, input bit msb, input bit bad_par);
    logic p;
    DataBits_i   = 2'(nbits - 5);
    ParityMode_i = 3'(pmode);
    TwoStop_i    = two;
    p_MsbFirst_i = msb;
    wait_clks(2);
    drive_bit(1'b0);
    p = 1'b0;
    for (int i = 0; i < nbits; i++) begin
      drive_bit(d[msb ? nbits - 1 - i : i]);
      p = p ^ d[i];
    end
    if (pmode >= 1 && pmode <= 4) begin
      case (pmode)
        1:       p = ~p;
        3:       p = 1'b1;
        4:       p = 1'b0;
        default: ;
      endcase
      drive_bit(p ^ bad_par);
    end
    drive_bit(1'b1);
    if (two) drive_bit(1'b1);
  endtask

  task automatic pop_word(input string tag, input logic [10:0] exp);
    check_eq(tag, fifo_bus.data_o, exp);
    fifo_bus.n_rd_i = 1'b0;
    @(negedge clk);
    fifo_bus.n_rd_i = 1'b1;
  endtask

  task automatic check_reset_state(input string tag);
    check_eq({tag, "_data"},  fifo_bus.data_o, 11'h000);
    check_eq({tag, "_empty"}, fifo_bus.p_empty_o, 1'b1);
    check_eq({tag, "_full"},  fifo_bus.p_full_o, 1'b0);
    check_eq({tag, "_level"}, fifo_bus.Level_o, 0);
    check_eq({tag, "_busy"},  p_Busy_o, 1'b0);
    check_eq({tag, "_perr"},  ParityErrorNum_o, 8'd0);
    check_eq({tag, "_ferr"},  FrameErrorNum_o, 8'd0);
    check_eq({tag, "_ovr"},   OverrunNum_o, 8'd0);
  endtask

  initial begin
    bit seen;
    rst = 1'b1;
    Rx_i = 1'b1;
    fifo_bus.n_rd_i = 1'b1;
    DataBits_i = 2'd3;
    ParityMode_i = 3'd0;
    TwoStop_i = 1'b0;
    p_MsbFirst_i = 1'b0;
    wait_clks(4);
    check_reset_state("rst");
    rst = 1'b0;
    wait_clks(4);

    // 8N1 LSB-first 0xA5
    check_eq("a5_level_before", fifo_bus.Level_o, 0);
    send_frame(8'hA5, 8, 0, 0, 0, 0);
    wait_clks(4);
    check_eq("a5_level_after", fifo_bus.Level_o, 1);
    check_eq("a5_empty", fifo_bus.p_empty_o, 1'b0);
    check_eq("a5_perr", ParityErrorNum_o, 8'd0);
    pop_word("a5_data", 11'h0A5);
    check_eq("a5_empty_after_pop", fifo_bus.p_empty_o, 1'b1);

    // 8E1 0x3C with wrong parity, then 7O2 MSB-first 0x55
    send_frame(8'h3C, 8, 2, 0, 0, 1);
    wait_clks(4);
    check_eq("3c_perr_cnt", ParityErrorNum_o, 8'd1);
    pop_word("3c_data", 11'h13C);
    send_frame(8'h55, 7, 1, 1, 1, 0);
    wait_clks(4);
    check_eq("55_level", fifo_bus.Level_o, 1);
    check_eq("55_perr_cnt", ParityErrorNum_o, 8'd1);
    check_eq("55_ferr_cnt", FrameErrorNum_o, 8'd0);
    pop_word("55_data", 11'h055);

    // False start: low for 5 ticks only
    DataBits_i = 2'd3;
    ParityMode_i = 3'd0;
    TwoStop_i = 1'b0;
    p_MsbFirst_i = 1'b0;
    Rx_i = 1'b0;
    wait_clks(12);
    check_eq("fs_busy_high", p_Busy_o, 1'b1);
    wait_clks(5 * TICK_DIV - 12);
    Rx_i = 1'b1;
    wait_clks(40);
    check_eq("fs_busy_low", p_Busy_o, 1'b0);
    check_eq("fs_level", fifo_bus.Level_o, 0);
    wait_clks(BIT_CLKS);
    send_frame(8'h81, 8, 0, 0, 0, 0);
    wait_clks(4);
    pop_word("81_data", 11'h081);

    // Break: low for 30 bit times
    Rx_i = 1'b0;
    wait_clks(30 * BIT_CLKS);
    Rx_i = 1'b1;
    wait_clks(2 * BIT_CLKS);
    check_eq("brk_level", fifo_bus.Level_o, 1);
    check_eq("brk_ferr_cnt", FrameErrorNum_o, 8'd1);
    check_eq("brk_busy", p_Busy_o, 1'b0);
    pop_word("brk_data", 11'h600);
    send_frame(8'hFF, 8, 0, 0, 0, 0);
    wait_clks(4);
    check_eq("ff_level", fifo_bus.Level_o, 1);
    check_eq("ff_ferr_cnt", FrameErrorNum_o, 8'd1);
    pop_word("ff_data", 11'h0FF);

    // Fill past depth: 0x01..0x05, no reads
    for (int i = 1; i <= 5; i++) send_frame(8'(i), 8, 0, 0, 0, 0);
    wait_clks(4);
    check_eq("ovr_full", fifo_bus.p_full_o, 1'b1);
    check_eq("ovr_level", fifo_bus.Level_o, 4);
    check_eq("ovr_cnt", OverrunNum_o, 8'd1);
    pop_word("ovr_pop1", 11'h001);
    pop_word("ovr_pop2", 11'h002);
    pop_word("ovr_pop3", 11'h003);
    pop_word("ovr_pop4", 11'h004);
    check_eq("ovr_empty", fifo_bus.p_empty_o, 1'b1);
    check_eq("ovr_full_clear", fifo_bus.p_full_o, 1'b0);
    fifo_bus.n_rd_i = 1'b0;
    @(negedge clk);
    fifo_bus.n_rd_i = 1'b1;
    check_eq("empty_pop_level", fifo_bus.Level_o, 0);
    check_eq("empty_pop_empty", fifo_bus.p_empty_o, 1'b1);

    // Pop in the write cycle while full
    for (int i = 8'h11; i <= 8'h14; i++) send_frame(8'(i), 8, 0, 0, 0, 0);
    wait_clks(4);
    check_eq("sim_full_before", fifo_bus.p_full_o, 1'b1);
    seen = 1'b0;
    fork
      send_frame(8'h15, 8, 0, 0, 0, 0);
      begin
        int budget;
        budget = 0;
        while (!p_Busy_o && budget < 200) begin
          @(negedge clk);
          budget++;
        end
        budget = 0;
        while (p_Busy_o && budget < 20 * BIT_CLKS) begin
          @(negedge clk);
          budget++;
        end
        if (!p_Busy_o) begin
          seen = 1'b1;
          fifo_bus.n_rd_i = 1'b0;
          @(negedge clk);
          fifo_bus.n_rd_i = 1'b1;
        end
      end
    join
    wait_clks(4);
    check_eq("sim_write_seen", seen, 1'b1);
    check_eq("sim_level", fifo_bus.Level_o, 4);
    check_eq("sim_full", fifo_bus.p_full_o, 1'b1);
    check_eq("sim_ovr_cnt", OverrunNum_o, 8'd1);
    pop_word("sim_pop1", 11'h012);
    pop_word("sim_pop2", 11'h013);
    pop_word("sim_pop3", 11'h014);
    pop_word("sim_pop4", 11'h015);
    check_eq("sim_empty", fifo_bus.p_empty_o, 1'b1);

    // Reset mid-frame with a word held and nonzero counters
    send_frame(8'h5A, 8, 0, 0, 0, 0);
    wait_clks(4);
    check_eq("mid_level_before", fifo_bus.Level_o, 1);
    Rx_i = 1'b0;
    wait_clks(3 * BIT_CLKS);
    check_eq("mid_busy_before", p_Busy_o, 1'b1);
    rst = 1'b1;
    @(negedge clk);
    check_reset_state("mid_rst");
    rst = 1'b0;
    Rx_i = 1'b1;
    wait_clks(2 * BIT_CLKS);
    check_eq("post_rst_level", fifo_bus.Level_o, 0);
    send_frame(8'hC3, 8, 0, 0, 0, 0);
    wait_clks(4);
    check_eq("c3_level", fifo_bus.Level_o, 1);
    pop_word("c3_data", 11'h0C3);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
